// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush scheduler.
// No logic here; the state encoding is shared with the stage registers and debug views.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_BUBBLE  = 2'd1,
    MD_WAIT    = 2'd2,
    MEM_FREEZE = 2'd3
  } state_t;

  // Per-cycle control bundle, in the same order as the top-level outputs.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic md_start;
  } ctrl_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam int          DEF_CNT_W      = 16;
  localparam int          DEF_MD_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter; increments one cycle after inc and sticks at all-ones.
// No backpressure; clear wins over inc.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Fixed-priority stall/flush scheduler: stage enables and flushes are combinational from state and inputs.
// Priority is mem wait > mult/div > load-use > branch; the mult/div unit is held by a start/done handshake with timeout.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MD_TIMEOUT = DEF_MD_TIMEOUT,
  parameter int TO_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             md_req_ex,
  input  logic             md_done,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_start,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam ctrl_t C_IDLE   = 9'b11111_000_0;
  localparam ctrl_t C_FREEZE = 9'b00000_000_0;
  localparam ctrl_t C_MD_GO  = 9'b00011_001_1;
  localparam ctrl_t C_MD_RUN = 9'b00011_001_0;
  localparam ctrl_t C_LU     = 9'b00111_010_0;
  localparam ctrl_t C_BR     = 9'b11111_100_0;
  localparam ctrl_t C_RESET  = 9'b00000_111_0;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MD_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t          state, state_nxt;
  ctrl_t           ctrl;
  logic [TO_W-1:0] to_cnt;
  logic            md_done_pend;
  logic            to_clr, md_timeout, pend_set;

  always_comb begin
    ctrl       = C_IDLE;
    state_nxt  = state;
    to_clr     = 1'b0;
    md_timeout = 1'b0;
    pend_set   = 1'b0;
    unique case (state)
      RUN, LU_BUBBLE, MEM_FREEZE: begin
        // LU_BUBBLE already holds the one bubble, so a repeated load_use is ignored there.
        if (dmem_wait) begin
          ctrl      = C_FREEZE;
          state_nxt = MEM_FREEZE;
        end else if (md_req_ex && (state != LU_BUBBLE)) begin
          ctrl      = C_MD_GO;
          to_clr    = 1'b1;
          state_nxt = MD_WAIT;
        end else if (load_use && (state != LU_BUBBLE)) begin
          ctrl      = C_LU;
          state_nxt = LU_BUBBLE;
        end else if (branch_taken) begin
          ctrl      = C_BR;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      MD_WAIT: begin
        ctrl = C_MD_RUN;
        // A frozen memory stage also blocks release, so a done pulse here is parked in md_done_pend.
        if (dmem_wait) begin
          ctrl.exmem_en = 1'b0;
          ctrl.memwb_en = 1'b0;
          pend_set      = md_done;
        end else if (md_done || md_done_pend) begin
          ctrl      = C_IDLE;
          state_nxt = RUN;
        end else if (to_cnt == TO_MAX) begin
          ctrl       = C_IDLE;
          md_timeout = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (!rst_n) begin
      ctrl = C_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      to_cnt       <= '0;
      md_done_pend <= 1'b0;
      md_error     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (to_clr) begin
        to_cnt <= '0;
      end else if ((state == MD_WAIT) && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + TO_ONE;
      end
      if (state_nxt != MD_WAIT) begin
        md_done_pend <= 1'b0;
      end else if (pend_set) begin
        md_done_pend <= 1'b1;
      end
      if (md_timeout) begin
        md_error <= 1'b1;
      end
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
          ifid_flush, idex_flush, exmem_flush, md_start} = ctrl;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (!ctrl.pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (ctrl.ifid_flush | ctrl.idex_flush | ctrl.exmem_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: table-driven vectors plus hand sequences for multi-cycle cases.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 4;

  // {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush | md_start}
  localparam logic [8:0] O_IDLE = 9'b11111_000_0;
  localparam logic [8:0] O_FRZ  = 9'b00000_000_0;
  localparam logic [8:0] O_MDS  = 9'b00011_001_1;
  localparam logic [8:0] O_MDW  = 9'b00011_001_0;
  localparam logic [8:0] O_MDF  = 9'b00000_001_0;
  localparam logic [8:0] O_LU   = 9'b00111_010_0;
  localparam logic [8:0] O_BR   = 9'b11111_100_0;
  localparam logic [8:0] O_RST  = 9'b00000_111_0;

  // Input codes {load_use, branch_taken, md_req_ex, md_done, dmem_wait}
  typedef struct packed {
    logic [4:0] in;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, load_use, branch_taken, md_req_ex, md_done, dmem_wait;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, md_start, md_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, md_start};

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .md_req_ex(md_req_ex), .md_done(md_done), .dmem_wait(dmem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .md_start(md_start), .md_error(md_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  vec_t       tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expected outputs, compare on the falling edge.
  task automatic step(input logic [4:0] in, input logic [8:0] exp, input string name);
    logic [8:0] e;
    {load_use, branch_taken, md_req_ex, md_done, dmem_wait} = in;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, {23'd0, outs}, {23'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(5'b00000, O_RST, "reset_outputs");
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_stall, exp_flush;
    rst_n = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
    md_req_ex = 1'b0; md_done = 1'b0; dmem_wait = 1'b0;

    tbl[0]  = {5'b00000, O_IDLE};  // idle in RUN
    tbl[1]  = {5'b10000, O_LU};    // load-use stall
    tbl[2]  = {5'b10000, O_IDLE};  // LU_BUBBLE ignores load_use
    tbl[3]  = {5'b11000, O_LU};    // load-use beats branch
    tbl[4]  = {5'b01000, O_BR};    // branch re-resolves
    tbl[5]  = {5'b01000, O_BR};
    tbl[6]  = {5'b00001, O_FRZ};   // enter MEM_FREEZE
    tbl[7]  = {5'b11001, O_FRZ};   // freeze ignores lu/branch
    tbl[8]  = {5'b10000, O_LU};    // release evaluates load-use same cycle
    tbl[9]  = {5'b00001, O_FRZ};   // dmem wait from LU_BUBBLE
    tbl[10] = {5'b01000, O_BR};    // release evaluates branch
    tbl[11] = {5'b00101, O_FRZ};   // dmem beats mult/div
    tbl[12] = {5'b00100, O_MDS};   // release starts mult/div
    tbl[13] = {5'b00100, O_MDW};   // no reissue of md_start
    tbl[14] = {5'b00011, O_MDF};   // done while frozen -> pending
    tbl[15] = {5'b00001, O_MDF};
    tbl[16] = {5'b00000, O_IDLE};  // pending done releases
    tbl[17] = {5'b00000, O_IDLE};
    tbl[18] = {5'b11100, O_MDS};   // mult/div beats load-use and branch
    tbl[19] = {5'b00000, O_MDW};   // pending flag was cleared
    tbl[20] = {5'b00010, O_IDLE};  // done releases
    tbl[21] = {5'b00010, O_IDLE};  // stray done in RUN ignored

    step(5'b00000, O_RST, "reset_outputs");
    step(5'b11111, O_RST, "reset_outputs_busy_inputs");
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    check("reset_md_error", 32'(md_error), 0);
    rst_n = 1'b1;

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
      if (!tbl[i].exp[8] && exp_stall < 15) exp_stall++;
      if ((|tbl[i].exp[3:1]) && exp_flush < 15) exp_flush++;
    end
    check("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check("table_md_error", 32'(md_error), 0);

    // Mult/div handshake: done arrives after five wait cycles.
    do_reset();
    step(5'b00100, O_MDS, "md_start_pulse");
    for (int i = 0; i < 5; i++) step(5'b00100, O_MDW, "md_wait");
    step(5'b00010, O_IDLE, "md_done_release");
    check("md_stall_cnt", 32'(stall_cnt), 6);
    check("md_flush_cnt", 32'(flush_cnt), 6);
    check("md_no_error", 32'(md_error), 0);

    // Timeout: release on the ninth wait cycle with MD_TIMEOUT=8.
    do_reset();
    step(5'b00100, O_MDS, "to_start");
    for (int i = 0; i < 8; i++) step(5'b00000, O_MDW, "to_wait");
    check("to_error_before", 32'(md_error), 0);
    step(5'b00000, O_IDLE, "to_release");
    check("to_error_set", 32'(md_error), 1);
    step(5'b00000, O_IDLE, "to_idle");
    step(5'b10000, O_LU, "to_back_in_run");
    check("to_error_sticky", 32'(md_error), 1);
    check("to_stall_cnt", 32'(stall_cnt), 10);
    do_reset();
    check("to_error_cleared", 32'(md_error), 0);

    // Memory freeze during mult/div with done in the second frozen cycle.
    step(5'b00100, O_MDS, "fz_start");
    step(5'b00001, O_MDF, "fz_frozen1");
    step(5'b00011, O_MDF, "fz_frozen_done");
    step(5'b00001, O_MDF, "fz_frozen3");
    step(5'b00000, O_IDLE, "fz_pend_release");
    step(5'b00000, O_IDLE, "fz_run");

    // Saturation, then reset in the middle of a mult/div wait.
    do_reset();
    for (int i = 0; i < 20; i++) step(5'b00001, O_FRZ, "sat_freeze");
    check("sat_stall_cnt", 32'(stall_cnt), 15);
    check("sat_flush_cnt", 32'(flush_cnt), 0);
    step(5'b00000, O_IDLE, "sat_release");
    step(5'b00100, O_MDS, "mid_start");
    step(5'b00000, O_MDW, "mid_wait1");
    step(5'b00000, O_MDW, "mid_wait2");
    rst_n = 1'b0;
    step(5'b00010, O_RST, "mid_reset_outputs");
    check("mid_stall_cnt", 32'(stall_cnt), 0);
    check("mid_flush_cnt", 32'(flush_cnt), 0);
    check("mid_md_error", 32'(md_error), 0);
    rst_n = 1'b1;
    step(5'b10000, O_LU, "mid_state_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It arbitrates four hazard sources by fixed priority and drives per-stage enables and flushes:
- data-memory wait
- multi-cycle mult/div occupancy of EX
- load-use hazard
- taken branch/jump in ID

It sequences the multi-cycle mult/div unit with a start/done handshake and keeps saturating stall/flush performance counters. It sits beside the pipeline registers and replaces ad-hoc enable logic in the stage registers.

Parameters:
- CNT_W, 16: width of the stall and flush performance counters.
- MD_TIMEOUT, 64: maximum cycles to wait for md_done before abort.
- TO_W, 7: timeout counter width; must satisfy 2**TO_W > MD_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_use  in  1  load in EX whose rt matches rs/rt of ID instruction (from hazard detector).
- branch_taken  in  1  ID-stage beq/bne/j resolved taken.
- md_req_ex  in  1  EX-stage instruction is mult/multu/div/divu.
- md_done  in  1  mult/div result valid; single-cycle pulse.
- dmem_wait  in  1  data memory not ready; level.
- pc_en  out  1  PC update enable (1 = advance).
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM register enable.
- memwb_en  out  1  MEM/WB register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load NOP into ID/EX.
- exmem_flush  out  1  load NOP into EX/MEM.
- md_start  out  1  single-cycle start pulse to mult/div unit.
- md_error  out  1  sticky: mult/div timeout occurred.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.
- flush_cnt  out  CNT_W  cycles with any flush=1, saturating.

Behaviour:
- Outputs are combinational from the registered state and current inputs.
- State, timeout counter, md_error, md_done_pend and the perf counters are registered and update on rising clk.
- Default (no event): all enables 1, all flushes 0, md_start 0.
- Reset (rst_n=0 at edge): state=RUN, timeout counter=0, md_done_pend=0, md_error=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0: all enables 0, all flushes 1, md_start 0.
- States are RUN, LU_BUBBLE, MD_WAIT and MEM_FREEZE; encoding comes from the shared package.
- RUN, evaluated in priority order, first match wins:
  1. dmem_wait: all enables 0 → MEM_FREEZE.
  2. md_req_ex: md_start=1; pc_en=ifid_en=idex_en=0; exmem_flush=1; timeout counter cleared → MD_WAIT.
  3. load_use: pc_en=ifid_en=0; idex_flush=1 → LU_BUBBLE.
  4. branch_taken: ifid_flush=1, PC advances to target → RUN.
  5. Otherwise → RUN.
- LU_BUBBLE: load_use is ignored (one bubble only). dmem_wait and branch_taken are handled as in RUN. md_req_ex cannot occur (EX holds the bubble). Exit → RUN, or MEM_FREEZE if dmem_wait.
- MD_WAIT:
  - Default outputs: pc_en=ifid_en=idex_en=0; exmem_flush=1; timeout counter +1 per cycle.
  - If dmem_wait: additionally exmem_en=memwb_en=0; a md_done arriving now sets md_done_pend.
  - Done condition: (md_done or md_done_pend) and !dmem_wait.
  - On done: all enables 1, exmem_flush=0 (result enters EX/MEM), md_done_pend cleared → RUN.
  - If the counter reaches MD_TIMEOUT without done: md_error←1; same release outputs as done → RUN.
  - md_start is never reissued in MD_WAIT.
- MEM_FREEZE:
  - While dmem_wait: all enables 0, no flushes, branch_taken/load_use ignored.
  - On dmem_wait=0: outputs are evaluated exactly as RUN rules 2-5 in that same cycle, and the next state follows those rules.
- Simultaneous events resolve by priority only. A taken branch coinciding with load_use yields the stall, not the flush; the branch re-resolves next cycle.
- Counters saturate at 2**CNT_W-1 with no wrap. The count condition uses the final output values of the cycle.
- Reset mid-MD_WAIT abandons the operation; md_error is cleared.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN=2'd0, LU_BUBBLE=2'd1, MD_WAIT=2'd2, MEM_FREEZE=2'd3);
  - the NOP encoding constant 32'h0000_0000 used by the flush targets;
  - the default CNT_W and MD_TIMEOUT.
- One sub-module, sat_counter (WIDTH, inc, clear → count), is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use, normal: load_use=1 one cycle in RUN → that cycle pc_en=ifid_en=0 and idex_flush=1. Next cycle load_use still 1 but state is LU_BUBBLE → all enables 1. stall_cnt=1, flush_cnt=1.
- Mult/div handshake: md_req_ex=1 in RUN → md_start pulses for exactly 1 cycle. md_done arrives 5 cycles later → 6 cycles with pc_en=0 and exmem_flush=1 except on the done cycle. Then RUN, stall_cnt=6.
- Timeout: md_req_ex=1, md_done never asserted, MD_TIMEOUT=4 → md_error=1 after 5 cycles and stays 1 until rst_n=0.
- Freeze during mult/div: dmem_wait=1 for 3 cycles while md_done pulses in the 2nd → md_done_pend=1. Release happens on the first cycle dmem_wait=0, with exmem_en=1 and exmem_flush=0.
- Priority: load_use=1 and branch_taken=1 together in RUN → stall, ifid_flush=0. Next cycle branch_taken=1 alone → ifid_flush=1, pc_en=1.
- Saturation and reset: CNT_W=4, hold dmem_wait=1 for 20 cycles → stall_cnt=15 with no wrap. Assert rst_n=0 mid-MD_WAIT → state RUN, all counters 0, enables 0 and flushes 1 while rst_n is low.
